// File: rtl/colour_conv_pkg.sv
// Shared constants for the RGB<->YUV colour-conversion paths: BT.601 coefficients (Q16),
// output offsets, component select and the RGB->YUV sequencer state encoding.
package colour_conv_pkg;

  localparam int unsigned AddrW = 18;

  localparam int CoefYR = 16843;
  localparam int CoefYG = 33030;
  localparam int CoefYB = 6423;
  localparam int OffY   = 16;

  localparam int CoefUR = -9699;
  localparam int CoefUG = -19071;
  localparam int CoefUB = 28770;
  localparam int OffU   = 128;

  localparam int CoefVR = 28770;
  localparam int CoefVG = -24117;
  localparam int CoefVB = -4653;
  localparam int OffV   = 128;

  typedef enum logic [1:0] {CompY, CompU, CompV} comp_e;

  typedef enum logic [3:0] {
    StIdle,
    StRdR,
    StRdG,
    StRdB,
    StCapB,
    StWrY,
    StWrU,
    StWrV,
    StDone
  } state_e;

endpackage

// File: rtl/rgb_to_yuv_conversion_if.sv
// Control and SRAM port bundle of the RGB->YUV converter; master is the converter side.
interface rgb_to_yuv_conversion_if;
  import colour_conv_pkg::*;

  logic             start;
  logic             busy;
  logic             done;
  logic [AddrW-1:0] R_addr;
  logic [15:0]      R_data;
  logic [AddrW-1:0] W_addr;
  logic [15:0]      W_data;
  logic             W_en;

  modport master (
    input  start, R_data,
    output busy, done, R_addr, W_addr, W_data, W_en
  );

  modport slave (
    output start, R_data,
    input  busy, done, R_addr, W_addr, W_data, W_en
  );

endinterface

// File: rtl/rgb2yuv_pixel.sv
// One pixel, one component: floor((cR*R + cG*G + cB*B) / 2^16) + offset, clamped to 0..255.
module rgb2yuv_pixel
  import colour_conv_pkg::*;
(
  input  logic [7:0] r_i,
  input  logic [7:0] g_i,
  input  logic [7:0] b_i,
  input  comp_e      sel_i,
  output logic [7:0] pix_o
);

  int cr, cg, cb, off, sum, val;

  always_comb begin
    cr  = CoefYR;
    cg  = CoefYG;
    cb  = CoefYB;
    off = OffY;
    unique case (sel_i)
      CompY: begin cr = CoefYR; cg = CoefYG; cb = CoefYB; off = OffY; end
      CompU: begin cr = CoefUR; cg = CoefUG; cb = CoefUB; off = OffU; end
      CompV: begin cr = CoefVR; cg = CoefVG; cb = CoefVB; off = OffV; end
      default: begin cr = CoefYR; cg = CoefYG; cb = CoefYB; off = OffY; end
    endcase
    sum = cr * int'(r_i) + cg * int'(g_i) + cb * int'(b_i);
    // Arithmetic shift floors negative sums rather than truncating toward zero.
    val = (sum >>> 16) + off;
    if (val < 0) begin
      pix_o = 8'd0;
    end else if (val > 255) begin
      pix_o = 8'd255;
    end else begin
      pix_o = val[7:0];
    end
  end

endmodule

// File: rtl/rgb_to_yuv_conversion.sv
// Frame sequencer: per 16-bit word reads R, G, B planes, then writes Y, U, V planes (7 cycles/word).
module rgb_to_yuv_conversion
  import colour_conv_pkg::*;
#(
  parameter int unsigned Words   = 38400,
  parameter int unsigned InBase  = 0,
  parameter int unsigned OutBase = 115200
) (
  input  logic                     clk,
  input  logic                     rst,
  rgb_to_yuv_conversion_if.master  bus_io
);

  localparam logic [AddrW-1:0] RBase = AddrW'(InBase);
  localparam logic [AddrW-1:0] GBase = AddrW'(InBase + Words);
  localparam logic [AddrW-1:0] BBase = AddrW'(InBase + 2 * Words);
  localparam logic [AddrW-1:0] YBase = AddrW'(OutBase);
  localparam logic [AddrW-1:0] UBase = AddrW'(OutBase + Words);
  localparam logic [AddrW-1:0] VBase = AddrW'(OutBase + 2 * Words);
  localparam logic [AddrW-1:0] LastK = AddrW'(Words - 1);

  state_e           state_q;
  logic [AddrW-1:0] k_q;
  logic             busy_q, done_q, w_en_q;
  logic [AddrW-1:0] r_addr_q, w_addr_q;
  logic [15:0]      r_q, g_q, b_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      k_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      w_en_q   <= 1'b0;
      r_addr_q <= '0;
      w_addr_q <= '0;
      r_q      <= '0;
      g_q      <= '0;
      b_q      <= '0;
    end else begin
      done_q <= 1'b0;
      w_en_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus_io.start) begin
            state_q  <= StRdR;
            k_q      <= '0;
            busy_q   <= 1'b1;
            r_addr_q <= RBase;
          end
        end
        StRdR: begin
          state_q  <= StRdG;
          r_addr_q <= GBase + k_q;
        end
        // Synchronous SRAM: data for the address issued last cycle is on R_data now.
        StRdG: begin
          state_q  <= StRdB;
          r_q      <= bus_io.R_data;
          r_addr_q <= BBase + k_q;
        end
        StRdB: begin
          state_q <= StCapB;
          g_q     <= bus_io.R_data;
        end
        StCapB: begin
          state_q  <= StWrY;
          b_q      <= bus_io.R_data;
          w_en_q   <= 1'b1;
          w_addr_q <= YBase + k_q;
        end
        StWrY: begin
          state_q  <= StWrU;
          w_en_q   <= 1'b1;
          w_addr_q <= UBase + k_q;
        end
        StWrU: begin
          state_q  <= StWrV;
          w_en_q   <= 1'b1;
          w_addr_q <= VBase + k_q;
        end
        StWrV: begin
          if (k_q == LastK) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q  <= StRdR;
            k_q      <= k_q + 1'b1;
            r_addr_q <= RBase + k_q + 1'b1;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  comp_e      sel;
  logic [7:0] pix_even, pix_odd;

  always_comb begin
    sel = CompY;
    unique case (state_q)
      StWrU:   sel = CompU;
      StWrV:   sel = CompV;
      default: sel = CompY;
    endcase
  end

  rgb2yuv_pixel u_pix_even (
    .r_i   (r_q[15:8]),
    .g_i   (g_q[15:8]),
    .b_i   (b_q[15:8]),
    .sel_i (sel),
    .pix_o (pix_even)
  );

  rgb2yuv_pixel u_pix_odd (
    .r_i   (r_q[7:0]),
    .g_i   (g_q[7:0]),
    .b_i   (b_q[7:0]),
    .sel_i (sel),
    .pix_o (pix_odd)
  );

  assign bus_io.busy   = busy_q;
  assign bus_io.done   = done_q;
  assign bus_io.R_addr = r_addr_q;
  assign bus_io.W_addr = w_addr_q;
  assign bus_io.W_en   = w_en_q;
  assign bus_io.W_data = w_en_q ? {pix_even, pix_odd} : 16'h0000;

endmodule

// File: tb/tb_rgb_to_yuv_conversion.sv
// Directed bench: two converter instances (2-word default bases, 3-word relocated bases).
module tb_rgb_to_yuv_conversion;

  logic clk;
  logic rst;

  rgb_to_yuv_conversion_if ifa ();
  rgb_to_yuv_conversion_if ifb ();

  rgb_to_yuv_conversion #(
    .Words   (2),
    .InBase  (0),
    .OutBase (115200)
  ) u_dut_a (
    .clk    (clk),
    .rst    (rst),
    .bus_io (ifa)
  );

  rgb_to_yuv_conversion #(
    .Words   (3),
    .InBase  (10),
    .OutBase (100)
  ) u_dut_b (
    .clk    (clk),
    .rst    (rst),
    .bus_io (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] mem_a [0:7];
  logic [15:0] mem_b [0:31];

  int unsigned wa_addr[$];
  logic [15:0] wa_data[$];
  int unsigned wb_addr[$];
  logic [15:0] wb_data[$];
  int unsigned rb_addr[$];
  int unsigned last_rb;
  int          done_cnt_a;

  int n_checks;
  int n_err;

  // Synchronous SRAM models plus write logs.
  always @(posedge clk) begin
    ifa.R_data <= (ifa.R_addr < 18'd8) ? mem_a[ifa.R_addr[2:0]] : 16'h0000;
    ifb.R_data <= (ifb.R_addr < 18'd32) ? mem_b[ifb.R_addr[4:0]] : 16'h0000;
    if (ifa.W_en) begin
      wa_addr.push_back(int'(ifa.W_addr));
      wa_data.push_back(ifa.W_data);
    end
    if (ifb.W_en) begin
      wb_addr.push_back(int'(ifb.W_addr));
      wb_data.push_back(ifb.W_data);
    end
    if (ifa.done) done_cnt_a <= done_cnt_a + 1;
  end

  always @(negedge clk) begin
    if (ifb.busy && int'(ifb.R_addr) != last_rb) begin
      rb_addr.push_back(int'(ifb.R_addr));
      last_rb = int'(ifb.R_addr);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse start on A; report cycle (edges after start) at which done is seen.
  task automatic run_frame_a(input bit poke, output int cyc, output logic busy1);
    @(negedge clk);
    ifa.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
    cyc   = 1;
    busy1 = ifa.busy;
    while (!ifa.done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      ifa.start = (poke && cyc == 5);
    end
    ifa.start = 1'b0;
  endtask

  int unsigned exp_wb_addr[9] = '{100, 103, 106, 101, 104, 107, 102, 105, 108};
  logic [15:0] exp_wb_data[9] = '{16'h1010, 16'h8080, 16'h8080,
                                  16'hEB51, 16'h805A, 16'h80EF,
                                  16'h1028, 16'h80EF, 16'h806D};
  int unsigned exp_rb_addr[9] = '{10, 13, 16, 11, 14, 17, 12, 15, 18};
  int unsigned exp_wa_addr[6] = '{115200, 115202, 115204, 115201, 115203, 115205};
  logic [15:0] exp_wa_data[6] = '{16'h1010, 16'h8080, 16'h8080,
                                  16'hEB51, 16'h805A, 16'h80EF};

  initial begin
    int   cyc;
    logic busy1;
    int   done_base;

    n_checks   = 0;
    n_err      = 0;
    done_cnt_a = 0;
    last_rb    = 32'hFFFF_FFFF;
    for (int i = 0; i < 8; i++) mem_a[i] = 16'h0000;
    for (int i = 0; i < 32; i++) mem_b[i] = 16'h0000;
    // A: word0 black, word1 even white / odd red.
    mem_a[1] = 16'hFFFF; mem_a[3] = 16'hFF00; mem_a[5] = 16'hFF00;
    // B: word0 black, word1 white/red, word2 odd pixel blue.
    mem_b[11] = 16'hFFFF; mem_b[14] = 16'hFF00; mem_b[17] = 16'hFF00; mem_b[18] = 16'h00FF;

    rst       = 1'b1;
    ifa.start = 1'b0;
    ifb.start = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy",   32'(ifa.busy),   32'd0);
    check_eq("rst_done",   32'(ifa.done),   32'd0);
    check_eq("rst_wen",    32'(ifa.W_en),   32'd0);
    check_eq("rst_raddr",  32'(ifa.R_addr), 32'd0);
    check_eq("rst_waddr",  32'(ifa.W_addr), 32'd0);
    check_eq("rst_wdata",  32'(ifa.W_data), 32'd0);
    rst = 1'b0;

    // Relocated 3-word frame: data, read order and write order.
    @(negedge clk);
    ifb.start = 1'b1;
    @(negedge clk);
    ifb.start = 1'b0;
    cyc = 1;
    while (!ifb.done && cyc < 80) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("b_done_cycle", 32'(cyc), 32'd22);
    check_eq("b_nwrites", 32'(wb_addr.size()), 32'd9);
    for (int i = 0; i < 9 && i < wb_addr.size(); i++) begin
      check_eq($sformatf("b_waddr%0d", i), 32'(wb_addr[i]), 32'(exp_wb_addr[i]));
      check_eq($sformatf("b_wdata%0d", i), 32'(wb_data[i]), 32'(exp_wb_data[i]));
    end
    check_eq("b_nreads", 32'(rb_addr.size()), 32'd9);
    for (int i = 0; i < 9 && i < rb_addr.size(); i++) begin
      check_eq($sformatf("b_raddr%0d", i), 32'(rb_addr[i]), 32'(exp_rb_addr[i]));
    end

    // 2-word frame timing, with a stray start mid-frame.
    run_frame_a(1'b1, cyc, busy1);
    check_eq("a_busy_c1", 32'(busy1), 32'd1);
    check_eq("a_done_cycle", 32'(cyc), 32'd15);
    check_eq("a_busy_in_done", 32'(ifa.busy), 32'd0);
    @(negedge clk);
    check_eq("a_done_1cyc", 32'(ifa.done), 32'd0);
    repeat (10) @(negedge clk);
    check_eq("a_no_restart", 32'(ifa.busy), 32'd0);
    check_eq("a_nwrites", 32'(wa_addr.size()), 32'd6);
    for (int i = 0; i < 6 && i < wa_addr.size(); i++) begin
      check_eq($sformatf("a_waddr%0d", i), 32'(wa_addr[i]), 32'(exp_wa_addr[i]));
      check_eq($sformatf("a_wdata%0d", i), 32'(wa_data[i]), 32'(exp_wa_data[i]));
    end

    // Reset while in WR_U: only the Y and U writes land, no done.
    wa_addr.delete();
    wa_data.delete();
    done_base = done_cnt_a;
    @(negedge clk);
    ifa.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_busy", 32'(ifa.busy), 32'd0);
    check_eq("midrst_wen",  32'(ifa.W_en), 32'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("midrst_nwrites", 32'(wa_addr.size()), 32'd2);
    check_eq("midrst_no_done", 32'(done_cnt_a - done_base), 32'd0);

    // Fresh frame after the aborted one.
    wa_addr.delete();
    wa_data.delete();
    run_frame_a(1'b0, cyc, busy1);
    check_eq("fresh_done_cycle", 32'(cyc), 32'd15);
    @(negedge clk);
    check_eq("fresh_nwrites", 32'(wa_addr.size()), 32'd6);
    if (wa_addr.size() == 6) begin
      check_eq("fresh_first_data", 32'(wa_data[0]), 32'h1010);
      check_eq("fresh_last_addr",  32'(wa_addr[5]), 32'd115205);
      check_eq("fresh_last_data",  32'(wa_data[5]), 32'h80EF);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
